// File: rtl/bp_be_circular_queue_ctrl_pkg.sv
// Shared helpers for the BE checker circular queue controller.
// Widths are derived here so the top and the retreat sub-module agree.
package bp_be_circular_queue_ctrl_pkg;

    // A single-entry buffer still needs a one-bit pointer, unlike plain $clog2.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_be_circular_ptr_retreat.sv
// Wrap-decrement of a circular-buffer pointer by up to slots_p entries.
// Works for non-power-of-two depths without a modulo or divide.
module bp_be_circular_ptr_retreat
    import bp_be_circular_queue_ctrl_pkg::*;
#(
    parameter int slots_p = 8,
    localparam int ptr_width_lp = safe_clog2(slots_p),
    localparam int cnt_width_lp = $clog2(slots_p + 1)
)
(
    input  logic [ptr_width_lp-1:0] ptr_i,
    input  logic [cnt_width_lp-1:0] n_i,
    output logic [ptr_width_lp-1:0] ptr_o
);

    // One extra bit so the top bit of the difference is a clean borrow.
    localparam int ext_width_lp = cnt_width_lp + 1;

    logic [ext_width_lp-1:0] ptr_ext;
    logic [ext_width_lp-1:0] n_ext;
    logic [ext_width_lp-1:0] diff;
    logic [ext_width_lp-1:0] diff_wrap;
    logic                    borrow;

    always_comb begin
        ptr_ext   = ext_width_lp'(ptr_i);
        n_ext     = ext_width_lp'(n_i);
        diff      = ptr_ext - n_ext;
        diff_wrap = diff + ext_width_lp'(slots_p);
        borrow    = diff[ext_width_lp-1];
        ptr_o     = borrow ? ptr_width_lp'(diff_wrap) : ptr_width_lp'(diff);
    end

endmodule

// File: rtl/bp_be_circular_queue_ctrl.sv
// Pointer/occupancy controller for a circular buffer with multi-entry
// enqueue/dequeue per cycle and write-pointer rollback on squash.
module bp_be_circular_queue_ctrl
    import bp_be_circular_queue_ctrl_pkg::*;
#(
    parameter int slots_p   = 8,
    parameter int max_enq_p = 2,
    parameter int max_deq_p = 2,
    localparam int ptr_width_lp = safe_clog2(slots_p),
    localparam int cnt_width_lp = $clog2(slots_p + 1),
    localparam int enq_width_lp = $clog2(max_enq_p + 1),
    localparam int deq_width_lp = $clog2(max_deq_p + 1)
)
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [enq_width_lp-1:0] enq_cnt_i,
    input  logic [deq_width_lp-1:0] deq_cnt_i,
    input  logic                    roll_v_i,
    input  logic [cnt_width_lp-1:0] roll_cnt_i,
    output logic [ptr_width_lp-1:0] wptr_o,
    output logic [ptr_width_lp-1:0] rptr_o,
    output logic [ptr_width_lp-1:0] rptr_p1_o,
    output logic [cnt_width_lp-1:0] count_o,
    output logic [cnt_width_lp-1:0] free_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int ext_width_lp = cnt_width_lp + 1;
    localparam logic [ext_width_lp-1:0] slots_ext_lp = ext_width_lp'(slots_p);

    logic [ptr_width_lp-1:0] wptr_r, wptr_n;
    logic [ptr_width_lp-1:0] rptr_r, rptr_n;
    logic [cnt_width_lp-1:0] count_r, count_n;
    logic                    overflow_r, overflow_n;
    logic                    underflow_r, underflow_n;

    logic                    enq_legal, deq_legal, roll_legal;
    logic [cnt_width_lp-1:0] enq_amt, deq_amt, roll_amt;
    logic [cnt_width_lp-1:0] free;

    logic [ext_width_lp-1:0] wptr_sum, wptr_sum_wrap;
    logic [ext_width_lp-1:0] rptr_sum, rptr_sum_wrap;
    logic [ext_width_lp-1:0] rptr_p1_sum, rptr_p1_sum_wrap;
    logic [ptr_width_lp-1:0] wptr_adv, rptr_adv, rptr_p1;
    logic [ptr_width_lp-1:0] wptr_retreat;

    assign free = cnt_width_lp'(slots_p) - count_r;

    // Legality looks only at registered occupancy: a same-cycle dequeue
    // never makes room for an enqueue, and a rollback may only discard
    // entries that survive the legal dequeue.
    always_comb begin
        deq_legal  = 32'(deq_cnt_i) <= 32'(count_r);
        deq_amt    = deq_legal ? cnt_width_lp'(deq_cnt_i) : '0;
        enq_legal  = 32'(enq_cnt_i) <= 32'(free);
        roll_legal = (32'(roll_cnt_i) + 32'(deq_amt)) <= 32'(count_r);
        enq_amt    = (!roll_v_i && enq_legal) ? cnt_width_lp'(enq_cnt_i) : '0;
        roll_amt   = (roll_v_i && roll_legal) ? roll_cnt_i : '0;
    end

    // Advance form: both candidate sums are formed in parallel and the
    // in-range one is chosen; applied amounts never exceed slots_p.
    always_comb begin
        wptr_sum         = ext_width_lp'(wptr_r) + ext_width_lp'(enq_amt);
        wptr_sum_wrap    = wptr_sum - slots_ext_lp;
        wptr_adv         = (wptr_sum >= slots_ext_lp) ? ptr_width_lp'(wptr_sum_wrap)
                                                      : ptr_width_lp'(wptr_sum);

        rptr_sum         = ext_width_lp'(rptr_r) + ext_width_lp'(deq_amt);
        rptr_sum_wrap    = rptr_sum - slots_ext_lp;
        rptr_adv         = (rptr_sum >= slots_ext_lp) ? ptr_width_lp'(rptr_sum_wrap)
                                                      : ptr_width_lp'(rptr_sum);

        rptr_p1_sum      = ext_width_lp'(rptr_r) + ext_width_lp'(1);
        rptr_p1_sum_wrap = rptr_p1_sum - slots_ext_lp;
        rptr_p1          = (rptr_p1_sum >= slots_ext_lp) ? ptr_width_lp'(rptr_p1_sum_wrap)
                                                         : ptr_width_lp'(rptr_p1_sum);
    end

    bp_be_circular_ptr_retreat #(
        .slots_p (slots_p)
    ) wptr_retreat_inst (
        .ptr_i (wptr_r),
        .n_i   (roll_amt),
        .ptr_o (wptr_retreat)
    );

    // Next-state selection; a squash owns the write pointer that cycle.
    always_comb begin
        wptr_n      = wptr_r;
        rptr_n      = rptr_adv;
        count_n     = count_r + enq_amt - deq_amt - roll_amt;
        overflow_n  = overflow_r;
        underflow_n = underflow_r;

        if (roll_v_i) begin
            wptr_n = wptr_retreat;
            if (!roll_legal)
                underflow_n = 1'b1;
        end else begin
            wptr_n = wptr_adv;
            if (!enq_legal)
                overflow_n = 1'b1;
        end

        if (!deq_legal)
            underflow_n = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r      <= '0;
            rptr_r      <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wptr_r      <= wptr_n;
            rptr_r      <= rptr_n;
            count_r     <= count_n;
            overflow_r  <= overflow_n;
            underflow_r <= underflow_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (32'(count_r) <= slots_p);
            assert (32'(wptr_r) < slots_p);
            assert (32'(rptr_r) < slots_p);
        end
    end

    assign wptr_o      = wptr_r;
    assign rptr_o      = rptr_r;
    assign rptr_p1_o   = rptr_p1;
    assign count_o     = count_r;
    assign free_o      = free;
    assign full_o      = (count_r == cnt_width_lp'(slots_p));
    assign empty_o     = (count_r == '0);
    assign overflow_o  = overflow_r;
    assign underflow_o = underflow_r;

endmodule

// File: tb/tb_bp_be_circular_queue_ctrl.sv
// Bench for bp_be_circular_queue_ctrl: a directed vector table followed by
// random traffic scored against an arithmetic model of the queue.
module tb_bp_be_circular_queue_ctrl;

    localparam int slots = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] enq_cnt = '0;
    logic [1:0] deq_cnt = '0;
    logic       roll_v = 1'b0;
    logic [2:0] roll_cnt = '0;
    logic [2:0] wptr, rptr, rptr_p1;
    logic [2:0] count, free;
    logic       full, empty, overflow, underflow;

    int compared = 0;
    int mismatched = 0;

    int m_w, m_r, m_c, m_ovf, m_unf;

    typedef struct {
        int enq; int deq; int rv; int rc; int rst;
        int w; int r; int c; int ovf; int unf;
    } vec_t;

    vec_t vecs[$];

    bp_be_circular_queue_ctrl #(
        .slots_p   (slots),
        .max_enq_p (2),
        .max_deq_p (2)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .enq_cnt_i   (enq_cnt),
        .deq_cnt_i   (deq_cnt),
        .roll_v_i    (roll_v),
        .roll_cnt_i  (roll_cnt),
        .wptr_o      (wptr),
        .rptr_o      (rptr),
        .rptr_p1_o   (rptr_p1),
        .count_o     (count),
        .free_o      (free),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (overflow),
        .underflow_o (underflow)
    );

    always #5 clk = ~clk;

    task applyStimulus(input int enq, input int deq, input int rv, input int rc, input int rst);
        @(negedge clk);
        enq_cnt  = 2'(enq);
        deq_cnt  = 2'(deq);
        roll_v   = (rv != 0);
        roll_cnt = 3'(rc);
        reset    = (rst != 0);
        @(posedge clk);
        #1;
    endtask

    task checkField(input string name, input int step, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, step, actual, expected);
        end
    endtask

    task checkOutput(input string tag, input int step, input int w, input int r,
                     input int c, input int ovf, input int unf);
        checkField({tag, ".wptr"},      step, int'(wptr),      w);
        checkField({tag, ".rptr"},      step, int'(rptr),      r);
        checkField({tag, ".rptr_p1"},   step, int'(rptr_p1),   (r + 1) % slots);
        checkField({tag, ".count"},     step, int'(count),     c);
        checkField({tag, ".free"},      step, int'(free),      slots - c);
        checkField({tag, ".full"},      step, int'(full),      (c == slots) ? 1 : 0);
        checkField({tag, ".empty"},     step, int'(empty),     (c == 0) ? 1 : 0);
        checkField({tag, ".overflow"},  step, int'(overflow),  ovf);
        checkField({tag, ".underflow"}, step, int'(underflow), unf);
    endtask

    // Reference: the queue as plain modular arithmetic on an occupancy count.
    task model_step(input int enq, input int deq, input int rv, input int rc, input int rst);
        int deq_take, roll_take, enq_take;
        if (rst != 0) begin
            m_w = 0; m_r = 0; m_c = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        deq_take = 0; roll_take = 0; enq_take = 0;
        if (deq <= m_c) deq_take = deq;
        else m_unf = 1;
        if (rv != 0) begin
            if (rc <= m_c - deq_take) begin
                roll_take = rc;
                m_w = (m_w - rc + slots) % slots;
            end else begin
                m_unf = 1;
            end
        end else begin
            if (enq <= slots - m_c) begin
                enq_take = enq;
                m_w = (m_w + enq) % slots;
            end else begin
                m_ovf = 1;
            end
        end
        m_r = (m_r + deq_take) % slots;
        m_c = m_c + enq_take - deq_take - roll_take;
    endtask

    initial begin
        //                     enq deq rv rc rst   w  r  c ovf unf
        vecs.push_back(vec_t'{2, 0, 0, 0, 1,  0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{2, 2, 1, 3, 1,  0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  2, 0, 2, 0, 0});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  4, 0, 4, 0, 0});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  0, 0, 6, 0, 0});
        vecs.push_back(vec_t'{1, 0, 0, 0, 0,  0, 0, 6, 1, 0});
        vecs.push_back(vec_t'{0, 2, 0, 0, 0,  0, 2, 4, 1, 0});
        vecs.push_back(vec_t'{0, 2, 0, 0, 0,  0, 4, 2, 1, 0});
        vecs.push_back(vec_t'{0, 2, 0, 0, 0,  0, 0, 0, 1, 0});
        vecs.push_back(vec_t'{0, 1, 0, 0, 0,  0, 0, 0, 1, 1});
        vecs.push_back(vec_t'{0, 0, 0, 0, 1,  0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  2, 0, 2, 0, 0});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  4, 0, 4, 0, 0});
        vecs.push_back(vec_t'{1, 0, 0, 0, 0,  5, 0, 5, 0, 0});
        vecs.push_back(vec_t'{0, 2, 0, 0, 0,  5, 2, 3, 0, 0});
        vecs.push_back(vec_t'{0, 2, 0, 0, 0,  5, 4, 1, 0, 0});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  1, 4, 3, 0, 0});
        vecs.push_back(vec_t'{0, 1, 0, 0, 0,  1, 5, 2, 0, 0});
        vecs.push_back(vec_t'{2, 2, 0, 0, 0,  3, 1, 2, 0, 0});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  5, 1, 4, 0, 0});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  1, 1, 6, 0, 0});
        vecs.push_back(vec_t'{0, 2, 0, 0, 0,  1, 3, 4, 0, 0});
        vecs.push_back(vec_t'{2, 0, 1, 3, 0,  4, 3, 1, 0, 0});
        vecs.push_back(vec_t'{1, 0, 0, 0, 0,  5, 3, 2, 0, 0});
        vecs.push_back(vec_t'{0, 1, 1, 2, 0,  5, 4, 1, 0, 1});
        vecs.push_back(vec_t'{0, 0, 1, 0, 0,  5, 4, 1, 0, 1});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  1, 4, 3, 0, 1});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  3, 4, 5, 0, 1});
        vecs.push_back(vec_t'{2, 0, 0, 0, 0,  3, 4, 5, 1, 1});
        vecs.push_back(vec_t'{2, 2, 0, 0, 0,  3, 0, 3, 1, 1});
        vecs.push_back(vec_t'{0, 0, 0, 0, 1,  0, 0, 0, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].enq, vecs[i].deq, vecs[i].rv, vecs[i].rc, vecs[i].rst);
            checkOutput("vec", i, vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].ovf, vecs[i].unf);
        end

        // Full-then-enqueue with simultaneous dequeue: the dequeue must not
        // make room for the enqueue in the same cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, 0, 0, 0, 0);
        end
        checkOutput("full", 0, 0, 0, 6, 0, 0);
        applyStimulus(2, 1, 0, 0, 0);
        checkOutput("full", 1, 0, 1, 5, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("full", 2, 0, 0, 0, 0, 0);

        model_step(0, 0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            int enq, deq, rv, rc, rst;
            enq = int'($urandom_range(0, 2));
            deq = int'($urandom_range(0, 2));
            rv  = ($urandom_range(0, 4) == 0) ? 1 : 0;
            rc  = int'($urandom_range(0, 5));
            rst = ($urandom_range(0, 79) == 0) ? 1 : 0;
            applyStimulus(enq, deq, rv, rc, rst);
            model_step(enq, deq, rv, rc, rst);
            checkOutput("rand", i, m_w, m_r, m_c, m_ovf, m_unf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
